// File: rtl/move_arbiter_pkg.sv
// Shared types and defaults for the two-player move arbiter: direction codes,
// FSM states, position width and the default playfield geometry.
package move_arbiter_pkg;

  localparam int POS_W      = 11;
  localparam int DEF_STEP   = 16;
  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    DIR_PX = 2'd0,
    DIR_MX = 2'd1,
    DIR_PY = 2'd2,
    DIR_MY = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/move_arbiter_if.sv
// Request/response and position bundle between the players' controllers and
// the move arbiter.
interface move_arbiter_if;
  import move_arbiter_pkg::*;

  // req[i] is a level request from player i; every grant is answered by exactly
  // one single-cycle ack[i] or reject[i] pulse, three cycles after the IDLE
  // cycle that sampled it, and req is not consulted again until the next IDLE.
  logic [1:0] req;
  logic [1:0] dir0;
  logic [1:0] dir1;
  logic [1:0] ack;
  logic [1:0] reject;
  pos_t       x0;
  pos_t       y0;
  pos_t       x1;
  pos_t       y1;
  logic       busy;
  state_t     state;

  modport slave (
    input  req, dir0, dir1,
    output ack, reject, x0, y0, x1, y1, busy, state
  );

  modport master (
    output req, dir0, dir1,
    input  ack, reject, x0, y0, x1, y1, busy, state
  );

endinterface

// File: rtl/move_arbiter_wrap_step.sv
// One-axis step with wrap-around; all arithmetic stays inside 0..limit-1 so no
// intermediate value can exceed the position width.
module wrap_step
  import move_arbiter_pkg::*;
(
  input  pos_t pos_i,
  input  logic minus_i,
  input  pos_t limit_i,
  input  pos_t step_i,
  output pos_t pos_o
);

  pos_t span;

  assign span = limit_i - step_i;

  always_comb begin
    pos_o = pos_i + step_i;
    if (minus_i) begin
      pos_o = (pos_i < step_i) ? pos_i + span : pos_i - step_i;
    end else if (pos_i >= span) begin
      pos_o = pos_i - span;
    end
  end

endmodule

// File: rtl/move_arbiter.sv
// Round-robin arbiter for two players' move requests: grants one move, computes
// the wrapped candidate position, then commits it or rejects it on collision.
module move_arbiter
  import move_arbiter_pkg::*;
#(
  parameter int STEP    = DEF_STEP,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int X0_INIT = 160,
  parameter int Y0_INIT = 240,
  parameter int X1_INIT = 480,
  parameter int Y1_INIT = 240
) (
  input logic          clk,
  input logic          reset,
  move_arbiter_if.slave bus
);

  state_t     state_q;
  logic       busy_q;
  logic       rr_q;
  logic       g_q;
  dir_t       dir_q;
  pos_t       cand_x_q, cand_y_q;
  logic [1:0] ack_q, rej_q;
  logic       upd_q;
  pos_t       x0_q, y0_q, x1_q, y1_q;

  logic grant_d;
  pos_t cur_x, cur_y, oth_x, oth_y;
  pos_t step_x, step_y;
  logic move_y, move_minus, collide;

  assign grant_d    = (bus.req == 2'b11) ? rr_q : bus.req[1];
  assign cur_x      = g_q ? x1_q : x0_q;
  assign cur_y      = g_q ? y1_q : y0_q;
  assign oth_x      = g_q ? x0_q : x1_q;
  assign oth_y      = g_q ? y0_q : y1_q;
  assign move_y     = (dir_q == DIR_PY) || (dir_q == DIR_MY);
  assign move_minus = (dir_q == DIR_MX) || (dir_q == DIR_MY);
  assign collide    = (cand_x_q == oth_x) && (cand_y_q == oth_y);

  wrap_step u_wrap_x (
    .pos_i   (cur_x),
    .minus_i (move_minus),
    .limit_i (pos_t'(WIDTH)),
    .step_i  (pos_t'(STEP)),
    .pos_o   (step_x)
  );

  wrap_step u_wrap_y (
    .pos_i   (cur_y),
    .minus_i (move_minus),
    .limit_i (pos_t'(HEIGHT)),
    .step_i  (pos_t'(STEP)),
    .pos_o   (step_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      rr_q     <= 1'b0;
      g_q      <= 1'b0;
      dir_q    <= DIR_PX;
      cand_x_q <= '0;
      cand_y_q <= '0;
      ack_q    <= 2'b00;
      rej_q    <= 2'b00;
      upd_q    <= 1'b0;
      x0_q     <= pos_t'(X0_INIT);
      y0_q     <= pos_t'(Y0_INIT);
      x1_q     <= pos_t'(X1_INIT);
      y1_q     <= pos_t'(Y1_INIT);
    end else begin
      ack_q <= 2'b00;
      rej_q <= 2'b00;
      upd_q <= 1'b0;
      // Position lands one cycle after the ack; g_q and cand_* still describe
      // the committed move here even if IDLE re-grants on this same edge.
      if (upd_q) begin
        if (g_q) begin
          x1_q <= cand_x_q;
          y1_q <= cand_y_q;
        end else begin
          x0_q <= cand_x_q;
          y0_q <= cand_y_q;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.req != 2'b00) begin
            g_q     <= grant_d;
            dir_q   <= dir_t'(grant_d ? bus.dir1 : bus.dir0);
            busy_q  <= 1'b1;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          cand_x_q <= move_y ? cur_x : step_x;
          cand_y_q <= move_y ? step_y : cur_y;
          state_q  <= ST_COMMIT;
        end
        ST_COMMIT: begin
          if (collide) begin
            rej_q <= onehot2(g_q);
          end else begin
            ack_q <= onehot2(g_q);
            upd_q <= 1'b1;
          end
          rr_q    <= ~g_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack    = ack_q;
  assign bus.reject = rej_q;
  assign bus.x0     = x0_q;
  assign bus.y0     = y0_q;
  assign bus.x1     = x1_q;
  assign bus.y1     = y1_q;
  assign bus.busy   = busy_q;
  assign bus.state  = state_q;

endmodule

// File: doc/move_arbiter.md
MOVE_ARBITER -- requirements
Module: move_arbiter

Interface
REQ-001 The block SHALL have parameter STEP, default 16, meaning the pixel distance of one move.
REQ-002 The block SHALL have parameter WIDTH, default 640, meaning the horizontal extent, with legal x values 0..WIDTH-1.
REQ-003 The block SHALL have parameter HEIGHT, default 480, meaning the vertical extent, with legal y values 0..HEIGHT-1.
REQ-004 The block SHALL have parameters X0_INIT=160, Y0_INIT=240, X1_INIT=480 and Y1_INIT=240, meaning the reset positions of player 0 and player 1.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 The block SHALL have port clk, input, width 1, the single clock; all logic is on the rising edge.
REQ-007 The block SHALL have port reset, input, width 1, the synchronous active-high reset.
REQ-008 The block SHALL have port req, input, width 2, where bit i is the level move request of player i.
REQ-009 The block SHALL have ports dir0 and dir1, input, width 2 each, giving the move direction of each player: 0 = +x, 1 = -x, 2 = +y, 3 = -y.
REQ-010 The block SHALL have port ack, output, width 2, a one-cycle pulse meaning the granted move was committed.
REQ-011 The block SHALL have port reject, output, width 2, a one-cycle pulse meaning the granted move was refused because of a collision.
REQ-012 The block SHALL have ports x0, y0, x1 and y1, output, width 11 each, giving the registered player positions.
REQ-013 The block SHALL have port busy, output, width 1, asserted high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, CALC and COMMIT, with transitions IDLE->CALC->COMMIT->IDLE.
REQ-015 In IDLE with req != 0, the block SHALL grant one player, latch that player's index and direction, and go to CALC.
REQ-016 Arbitration SHALL be round-robin: if both requests are set, the player indicated by the rr pointer wins; if only one request is set, that player wins regardless of the pointer.
REQ-017 The rr pointer SHALL move to the non-granted player after every COMMIT, whether the result was ack or reject.
REQ-018 In CALC, the block SHALL register a candidate position for the granted player.
REQ-019 +x wrap rule: if x+STEP >= WIDTH, the candidate x SHALL be x+STEP-WIDTH; otherwise x+STEP.
REQ-020 -x wrap rule: if x < STEP, the candidate x SHALL be x+WIDTH-STEP; otherwise x-STEP.
REQ-021 The y axis SHALL follow the same wrap rules as REQ-019 and REQ-020, using HEIGHT.
REQ-022 All position arithmetic SHALL be 11-bit unsigned, with no intermediate overflow.
REQ-023 In COMMIT, if the candidate equals the other player's current (x,y), the block SHALL pulse reject[g] for one cycle and leave both positions unchanged.
REQ-024 In COMMIT, if there is no collision, the block SHALL update the granted player's position and pulse ack[g] for one cycle.
REQ-025 Latency SHALL be fixed: ack or reject is asserted in the 3rd cycle after the IDLE cycle that sampled req, and the updated position is visible on the cycle after the ack pulse.
REQ-026 A move SHALL be granted at most once every 3 cycles.
REQ-027 The grant SHALL be latched: dropping req or changing dir after the grant SHALL NOT affect the in-flight move.
REQ-028 req is a level signal: if it is still high in the IDLE cycle after COMMIT, a new move SHALL be issued for it.
REQ-029 ack and reject SHALL never both be high, and at most one bit of either SHALL be high in any cycle.
REQ-030 The player that is not granted SHALL keep its position unchanged throughout the operation.

Reset
REQ-031 On reset, the block SHALL return the FSM to IDLE, set rr pointer=0, set ack=0, reject=0 and busy=0, and load x0=X0_INIT, y0=Y0_INIT, x1=X1_INIT and y1=Y1_INIT.
REQ-032 Reset asserted during CALC or COMMIT SHALL abort the in-flight move: no ack or reject is produced and positions take their init values.
REQ-033 Reset SHALL take priority over every other action in the same cycle.

Structure
REQ-034 The direction encodings, the FSM state enum and the default STEP/WIDTH/HEIGHT values SHALL live in a shared package used by the input controllers.
REQ-035 The wrap arithmetic SHALL be one sub-module, wrap_step (a position, a direction bit, a limit and a step in; the new position out), instantiated once per axis.

Verification
REQ-036 The bench SHALL cover: reset, then req=01 with dir0=0 -> ack=01 on the 3rd cycle, then x0=176, y0=240.
REQ-037 The bench SHALL cover: x0=0 and dir0=1 -> x0=624; y1=464 and dir1=2 -> y1=0.
REQ-038 The bench SHALL cover: req=11 held for 6 cycles after reset -> player 0 is granted first, then player 1, with ack order 01 then 10.
REQ-039 The bench SHALL cover: x0=464, y0=240, x1=480, y1=240, dir0=0 -> reject=01 and x0 stays 464.
REQ-040 The bench SHALL cover: reset pulsed during CALC -> no ack or reject pulse, and all positions return to their init values the next cycle.
REQ-041 The bench SHALL cover: req dropped the cycle after the grant -> ack still pulses and the position updates once.
